// File: rtl/serial_subtractor_d_if.sv
// Handshake and operand/result bundle for serial_subtractor_d.
//   start      : request an operation (master -> slave)
//   a, b       : minuend / subtrahend (master -> slave)
//   diff       : a - b mod 2^WIDTH (slave -> master)
//   borrow_out : 1 iff a < b unsigned (slave -> master)
//   zero       : 1 iff diff == 0 (slave -> master)
//   busy       : high while the serial datapath is running (slave -> master)
//   done       : one-cycle pulse when diff/borrow_out/zero become valid
interface serial_subtractor_d_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b,
    input  diff, borrow_out, zero, busy, done
  );

  modport slave (
    input  start, a, b,
    output diff, borrow_out, zero, busy, done
  );
endinterface

// File: rtl/serial_subtractor_d.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, LSB first, one bit per clock
// through a single full-subtractor cell and a borrow flip-flop.
//   clk : clock, rising edge
//   rst : synchronous reset, active-high
//   bus : serial_subtractor_d_if slave (start/a/b in, diff/borrow_out/zero/busy/done out)
// Timing: start accepted at edge k -> busy in cycles k+1..k+WIDTH, done in
// cycle k+WIDTH+1. Results are held until the next operation completes.
module serial_subtractor_d #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_subtractor_d_if.slave  bus
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh, b_sh, r_sh, diff_q;
  logic             br, borrow_q, zero_q;
  logic [CW-1:0]    count;

  logic             a0, b0, d, br_next;
  logic [WIDTH-1:0] r_next;
  logic             busy_c, done_c;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    a0      = a_sh[0];
    b0      = b_sh[0];
    d       = a0 ^ b0 ^ br;
    br_next = (~a0 & b0) | (~(a0 ^ b0) & br);
    r_next  = {d, r_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state)
      IDLE: if (bus.start) state_next = RUN;
      RUN: begin
        busy_c = 1'b1;
        if (count == LAST) state_next = DONE;
      end
      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result outputs are loaded from the final shift value on the last RUN edge
  // so they are valid in the same cycle that done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      br       <= 1'b0;
      count    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            r_sh  <= '0;
            br    <= 1'b0;
            count <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= r_next;
          br    <= br_next;
          count <= count + CW'(1);
          if (count == LAST) begin
            diff_q   <= r_next;
            borrow_q <= br_next;
            zero_q   <= (r_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.zero       = zero_q;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;

endmodule
